// File: rtl/read_iq_deinterleave_if.sv
// Byte-in / sample-out FIFO handshake bundle for read_iq_deinterleave.
// The deinterleaver is the master; the surrounding FIFOs (or a bench) are the slave.
interface read_iq_deinterleave_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]                   in_dout;
    logic                         in_empty;
    logic                         in_rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] out_din;
    logic [NUM_CH-1:0]            out_wr_en;
    logic [NUM_CH-1:0]            out_full;

    modport master (
        input  in_dout,
        input  in_empty,
        input  out_full,
        output in_rd_en,
        output out_din,
        output out_wr_en
    );

    modport slave (
        output in_dout,
        output in_empty,
        output out_full,
        input  in_rd_en,
        input  out_din,
        input  out_wr_en
    );
endinterface

// File: rtl/read_iq_deinterleave.sv
// Pops bytes from a FWFT FIFO, assembles little-endian frames of NUM_CH interleaved samples,
// and writes every channel's sign-extended, scaled sample to its own FIFO in one cycle.
module read_iq_deinterleave #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned BYTES_PER_SAMPLE = 2,
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned QUANT_BITS       = 10,
    parameter int unsigned COUNT_WIDTH      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   resync,
    read_iq_deinterleave_if.master fifo_io,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   busy
);
    localparam int unsigned FrameBytes = NUM_CH * BYTES_PER_SAMPLE;
    localparam int unsigned SampleBits = 8 * BYTES_PER_SAMPLE;
    localparam int unsigned BcntW      = (FrameBytes > 1) ? $clog2(FrameBytes) : 1;
    localparam logic [BcntW-1:0] LastByte = BcntW'(FrameBytes - 1);

    if (DATA_WIDTH < SampleBits + QUANT_BITS) begin : g_width_check
        $error("DATA_WIDTH cannot hold a sign-extended sample shifted by QUANT_BITS");
    end
    if (BYTES_PER_SAMPLE < 1 || BYTES_PER_SAMPLE > 4) begin : g_bps_check
        $error("BYTES_PER_SAMPLE must be in 1..4");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_ch_check
        $error("NUM_CH must be in 1..8");
    end

    typedef enum logic [0:0] {StGather, StEmit} state_e;

    state_e                       state_q;
    logic [BcntW-1:0]             bcnt_q;
    logic [8*FrameBytes-1:0]      frame_q;
    logic [NUM_CH*DATA_WIDTH-1:0] din_q;
    logic [NUM_CH-1:0]            wr_en_q;
    logic [COUNT_WIDTH-1:0]       count_q;

    logic                         rd_en;
    logic [NUM_CH*DATA_WIDTH-1:0] conv;
    logic [SampleBits-1:0]        raw;
    logic [DATA_WIDTH-1:0]        ext;

    // Reset gates the pop so no byte is consumed while the frame state is being cleared.
    assign rd_en = !reset && (state_q == StGather) && !fifo_io.in_empty && !resync;

    always_comb begin
        conv = '0;
        raw  = '0;
        ext  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            raw = frame_q[c*SampleBits +: SampleBits];
            ext = {DATA_WIDTH{raw[SampleBits-1]}};
            ext[SampleBits-1:0] = raw;
            conv[c*DATA_WIDTH +: DATA_WIDTH] = ext << QUANT_BITS;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StGather;
            bcnt_q  <= '0;
            frame_q <= '0;
            din_q   <= '0;
            wr_en_q <= '0;
            count_q <= '0;
        end else begin
            wr_en_q <= '0;
            if (resync) begin
                // Drops both a partial frame and a completed frame still waiting to be written.
                bcnt_q  <= '0;
                state_q <= StGather;
            end else begin
                unique case (state_q)
                    StGather: begin
                        if (rd_en) begin
                            for (int b = 0; b < FrameBytes; b++) begin
                                if (bcnt_q == BcntW'(b)) begin
                                    frame_q[8*b +: 8] <= fifo_io.in_dout;
                                end
                            end
                            if (bcnt_q == LastByte) begin
                                bcnt_q  <= '0;
                                state_q <= StEmit;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                    StEmit: begin
                        // All channels are written together or not at all.
                        if (fifo_io.out_full == '0) begin
                            wr_en_q <= '1;
                            din_q   <= conv;
                            count_q <= count_q + 1'b1;
                            state_q <= StGather;
                        end
                    end
                    default: state_q <= StGather;
                endcase
            end
        end
    end

    assign fifo_io.in_rd_en  = rd_en;
    assign fifo_io.out_din   = din_q;
    assign fifo_io.out_wr_en = wr_en_q;
    assign frame_count       = count_q;
    assign busy              = (bcnt_q != '0) || (state_q == StEmit);

endmodule

// File: tb/tb_read_iq_deinterleave.sv
// Randomised bench for read_iq_deinterleave: a queue-based frame model checked every cycle,
// plus directed frames with hand-computed sample values.
module tb_read_iq_deinterleave;
    localparam int unsigned Fb = 4;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        resync   = 1'b0;
    logic        resync_b = 1'b0;
    logic [31:0] count_a;
    logic [31:0] count_b;
    logic        busy_a;
    logic        busy_b;

    read_iq_deinterleave_if #(.NUM_CH(2), .DATA_WIDTH(32)) ifa ();
    read_iq_deinterleave_if #(.NUM_CH(4), .DATA_WIDTH(32)) ifb ();

    read_iq_deinterleave dut_a (
        .clock       (clock),
        .reset       (reset),
        .resync      (resync),
        .fifo_io     (ifa),
        .frame_count (count_a),
        .busy        (busy_a)
    );

    read_iq_deinterleave #(
        .DATA_WIDTH       (32),
        .BYTES_PER_SAMPLE (1),
        .NUM_CH           (4),
        .QUANT_BITS       (0),
        .COUNT_WIDTH      (32)
    ) dut_b (
        .clock       (clock),
        .reset       (reset),
        .resync      (resync_b),
        .fifo_io     (ifb),
        .frame_count (count_b),
        .busy        (busy_b)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  src_q[$];
    int          rd_idx   = 0;
    logic [7:0]  partial[$];
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];
    int          wr_base  = 0;
    int          exp_count = 0;
    logic        pop_pending = 1'b0;
    logic        will_write  = 1'b0;
    logic        gap_en      = 1'b0;
    logic        full_rand   = 1'b0;
    logic [1:0]  full_forced = 2'b00;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Signed little-endian sample of 'bps' bytes, scaled by 2^qb, wrapped to 32 bits.
    function automatic logic [31:0] conv(input longint raw, input int bps, input int qb);
        longint half;
        longint v;
        half = longint'(1) <<< (8 * bps - 1);
        v = raw;
        if (v >= half) v = v - 2 * half;
        v = v * (longint'(1) <<< qb);
        return v[31:0];
    endfunction

    // Upstream FWFT FIFO and downstream full flags for instance A.
    initial begin
        ifa.in_empty = 1'b1;
        ifa.in_dout  = 8'h00;
        ifa.out_full = 2'b00;
        forever begin
            @(posedge clock);
            #1;
            if (reset) rd_idx = src_q.size();
            else if (pop_pending && rd_idx < src_q.size()) rd_idx++;
            ifa.in_empty = (rd_idx >= src_q.size()) || (gap_en && ($urandom_range(0, 99) < 35));
            ifa.in_dout  = (rd_idx < src_q.size()) ? src_q[rd_idx] : 8'($urandom);
            if (full_rand)
                ifa.out_full = ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'b00;
            else
                ifa.out_full = full_forced;
        end
    end

    // Frame-level model and per-cycle comparison for instance A.
    initial begin
        logic [63:0] e;
        logic        emit_ready;
        forever begin
            @(negedge clock);
            if (reset) begin
                partial.delete();
                exp_q.delete();
                exp_count   = 0;
                will_write  = 1'b0;
                pop_pending = 1'b0;
            end else begin
                check("wr_en", ifa.out_wr_en, will_write ? 2'b11 : 2'b00);
                if (ifa.out_wr_en != 2'b00) begin
                    wr_log.push_back(ifa.out_din);
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    else e = 64'hx;
                    check("out_din", ifa.out_din, e);
                    exp_count++;
                end
                check("frame_count", count_a, exp_count);
                emit_ready = (exp_q.size() > 0);
                check("busy", busy_a, (partial.size() != 0) || emit_ready);
                if (emit_ready) check("rd_en_while_pending", ifa.in_rd_en, 1'b0);
                else if (!ifa.in_empty && !resync) check("rd_en_gather", ifa.in_rd_en, 1'b1);
                will_write = emit_ready && (ifa.out_full == 2'b00) && !resync;
                if (resync) begin
                    partial.delete();
                    if (emit_ready) void'(exp_q.pop_back());
                end
                pop_pending = ifa.in_rd_en;
                if (ifa.in_rd_en) begin
                    partial.push_back(ifa.in_dout);
                    if (partial.size() == Fb) begin
                        exp_q.push_back({conv({partial[3], partial[2]}, 2, 10),
                                         conv({partial[1], partial[0]}, 2, 10)});
                        partial.delete();
                    end
                end
            end
        end
    end

    task automatic push4(input logic [7:0] b0, b1, b2, b3);
        src_q.push_back(b0);
        src_q.push_back(b1);
        src_q.push_back(b2);
        src_q.push_back(b3);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((rd_idx < src_q.size() || exp_q.size() > 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, n < budget, 1'b1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic wait_partial(input int want, input int budget);
        int n = 0;
        while (partial.size() != want && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("partial_timeout", n < budget, 1'b1);
    endtask

    task automatic wait_pending(input int budget);
        int n = 0;
        while (exp_q.size() == 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("pending_timeout", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_wr_en", ifa.out_wr_en, 2'b00);
        check("rst_din", ifa.out_din, 64'h0);
        check("rst_count", count_a, 32'd0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rd_en", ifa.in_rd_en, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wr_base = wr_log.size();
    endtask

    logic [7:0] bvec [4];

    initial begin
        bvec = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        ifb.in_empty = 1'b1;
        ifb.in_dout  = 8'h00;
        ifb.out_full = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        check("init_wr_en", ifa.out_wr_en, 2'b00);
        check("init_count", count_a, 32'd0);
        check("init_busy", busy_a, 1'b0);
        check("init_b_din", ifb.out_din, 128'h0);
        reset = 1'b0;

        // Four 1-byte channels, no scaling.
        for (int i = 0; i < 4; i++) begin
            ifb.in_dout  = bvec[i];
            ifb.in_empty = 1'b0;
            @(posedge clock);
            #1;
        end
        ifb.in_empty = 1'b1;
        check("b_no_early_write", ifb.out_wr_en, 4'h0);
        check("b_busy_emit", busy_b, 1'b1);
        @(posedge clock);
        #1;
        check("b_wr_en", ifb.out_wr_en, 4'hF);
        check("b_din", ifb.out_din, {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF80, 32'h0000007F});
        check("b_count", count_b, 32'd1);
        check("b_busy_idle", busy_b, 1'b0);
        @(posedge clock);
        #1;
        check("b_wr_single", ifb.out_wr_en, 4'h0);
        check("b_din_hold", ifb.out_din, {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFF80, 32'h0000007F});

        // Basic frame.
        do_reset();
        push4(8'h34, 8'h12, 8'hFE, 8'hFF);
        wait_idle("t1_timeout", 50);
        check("t1_writes", wr_log.size() - wr_base, 1);
        if (wr_log.size() > wr_base) check("t1_din", wr_log[wr_base], {32'hFFFFF800, 32'h0048D000});
        check("t1_count", count_a, 32'd1);

        // Downstream stall on one channel holds the whole frame.
        do_reset();
        full_forced = 2'b10;
        push4(8'h34, 8'h12, 8'hFE, 8'hFF);
        src_q.push_back(8'hAA);
        src_q.push_back(8'hBB);
        wait_pending(50);
        repeat (5) @(posedge clock);
        #1;
        check("t2_no_write", wr_log.size() - wr_base, 0);
        check("t2_no_pop", src_q.size() - rd_idx, 2);
        full_forced = 2'b00;
        wait_idle("t2_timeout", 50);
        check("t2_writes", wr_log.size() - wr_base, 1);
        if (wr_log.size() > wr_base) check("t2_din", wr_log[wr_base], {32'hFFFFF800, 32'h0048D000});
        check("t2_count", count_a, 32'd1);

        // Resync drops a partial frame.
        do_reset();
        src_q.push_back(8'h34);
        src_q.push_back(8'h12);
        wait_partial(2, 50);
        resync = 1'b1;
        @(posedge clock);
        #1;
        resync = 1'b0;
        push4(8'h01, 8'h00, 8'h00, 8'h80);
        wait_idle("t3_timeout", 50);
        check("t3_writes", wr_log.size() - wr_base, 1);
        if (wr_log.size() > wr_base) check("t3_din", wr_log[wr_base], {32'hFE000000, 32'h00000400});
        check("t3_count", count_a, 32'd1);

        // Random stream with input gaps and random downstream back-pressure.
        do_reset();
        gap_en    = 1'b1;
        full_rand = 1'b1;
        for (int f = 0; f < 400; f++)
            push4(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        wait_idle("t4_timeout", 20000);
        gap_en    = 1'b0;
        full_rand = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("t4_writes", wr_log.size() - wr_base, 400);
        check("t4_count", count_a, 32'd400);

        // Async reset mid-frame, then mid-stall with a previous frame on the outputs.
        do_reset();
        src_q.push_back(8'h55);
        src_q.push_back(8'h66);
        wait_partial(2, 50);
        do_reset();
        push4(8'h34, 8'h12, 8'hFE, 8'hFF);
        wait_idle("t6_first_timeout", 50);
        full_forced = 2'b11;
        push4(8'h11, 8'h22, 8'h33, 8'h44);
        wait_pending(50);
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        full_forced = 2'b00;
        push4(8'h01, 8'h00, 8'h00, 8'h80);
        wait_idle("t6_timeout", 50);
        check("t6_writes", wr_log.size() - wr_base, 1);
        if (wr_log.size() > wr_base) check("t6_din", wr_log[wr_base], {32'hFE000000, 32'h00000400});
        check("t6_count", count_a, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
